// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, STAGES-deep register pipeline with per-stage valid
// bits, valid/ready back-pressure and bubble collapse.
module dff_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int OW = $clog2(STAGES+1);

    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_d [STAGES];
    logic [OW-1:0]     r_occ;

    logic [STAGES-1:0] w_adv;
    logic              w_blk;
    logic              w_in_xfer;
    logic              w_out_xfer;

    // A stage advances unless every stage downstream is full and the
    // consumer is stalled; this is the unrolled form of the advance chain.
    always_comb begin
        w_adv = '0;
        w_blk = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            w_blk = ~out_ready;
            for (int j = i + 1; j < STAGES; j++) begin
                w_blk = w_blk & r_v[j];
            end
            w_adv[i] = r_v[i] & ~w_blk;
        end
    end

    assign in_ready   = ~(&r_v & ~out_ready) & ~flush;
    assign out_valid  = r_v[STAGES-1] & ~flush;
    assign out_data   = r_d[STAGES-1];
    assign occupancy  = r_occ;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    // Stage registers: data moves only with a valid word, flush drops valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_d[i] <= '0;
            end
        end else if (flush) begin
            r_v <= '0;
        end else begin
            for (int i = STAGES - 1; i >= 1; i--) begin
                if (w_adv[i-1]) begin
                    r_v[i] <= 1'b1;
                    r_d[i] <= r_d[i-1];
                end else if (w_adv[i]) begin
                    r_v[i] <= 1'b0;
                end
            end
            if (w_in_xfer) begin
                r_v[0] <= 1'b1;
                r_d[0] <= in_data;
            end else if (w_adv[0]) begin
                r_v[0] <= 1'b0;
            end
        end
    end

    // Occupancy tracks accepted minus delivered words.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OW'(w_in_xfer) - OW'(w_out_xfer);
        end
    end

endmodule
